// File: rtl/lcd_frame_driver.sv
// HD44780-class character LCD controller: ROWS x COLS frame buffer,
// power-up init, and row-by-row streaming on an 8- or 4-bit bus.
module lcd_frame_driver #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int ROWS        = 4,
    parameter int COLS        = 16,
    parameter int BUS_WIDTH   = 8,
    parameter int POWERUP_US  = 40000,
    parameter int CMD_US      = 50,
    parameter int CLEAR_US    = 2000,
    parameter int E_PULSE_CYC = 25
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]  wr_addr,
    input  logic [7:0]                    wr_data,
    input  logic                          refresh_req,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          lcd_rs,
    output logic                          lcd_rw,
    output logic                          lcd_e,
    output logic [7:0]                    lcd_data
);
    localparam int CPU     = CLK_HZ / 1_000_000;
    localparam int DEPTH   = ROWS * COLS;
    localparam int AW      = $clog2(DEPTH);
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam bit BUS4    = (BUS_WIDTH == 4);
    localparam int N_INIT  = BUS4 ? 9 : 8;
    localparam int PWR_CYC = POWERUP_US * CPU;
    localparam int I41_CYC = 4100 * CPU;
    localparam int I01_CYC = 100 * CPU;
    localparam int CMD_CYC = CMD_US * CPU;
    localparam int CLR_CYC = CLEAR_US * CPU;
    localparam int M1      = (PWR_CYC > I41_CYC) ? PWR_CYC : I41_CYC;
    localparam int M2      = (M1 > CLR_CYC) ? M1 : CLR_CYC;
    localparam int M3      = (M2 > CMD_CYC) ? M2 : CMD_CYC;
    localparam int MAX_CYC = (M3 > E_PULSE_CYC) ? M3 : E_PULSE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] E_CNT   = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] PWR_CNT = CNT_W'((PWR_CYC > 0) ? PWR_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_ROW_ADDR, S_CHAR, S_FRAME_END
    } state_t;

    typedef enum logic [2:0] {
        X_IDLE, X_SETUP, X_HIGH, X_LOW, X_WAIT
    } phase_t;

    state_t           state, state_nx;
    phase_t           phase;
    logic [RW-1:0]    row, row_nx;
    logic [CW-1:0]    col, col_nx;
    logic [3:0]       step, step_nx, init_k;
    logic [CNT_W-1:0] cnt, wait_reg, iss_wait;
    logic [3:0]       lo_nib;
    logic             lo_pend, dirty, done;
    logic             iss, iss_init, iss_addr, iss_char, iss_nib;
    logic [7:0]       iss_byte, row_off;
    logic [AW-1:0]    rd_addr;
    logic             wr_ok, start_frame;
    logic [7:0]       fb [DEPTH];

    function automatic logic [7:0] init_byte(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: init_byte = 8'h30;
            4'd3:             init_byte = 8'h20;
            4'd4:             init_byte = BUS4 ? 8'h28 : 8'h38;
            4'd5:             init_byte = 8'h08;
            4'd6:             init_byte = 8'h01;
            4'd7:             init_byte = 8'h06;
            default:          init_byte = 8'h0C;
        endcase
    endfunction

    assign lcd_rw = 1'b0;
    assign done = (phase == X_WAIT && cnt == '0) ||
                  (phase == X_HIGH && cnt == '0 && !lo_pend && wait_reg == '0);
    assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH));
    assign start_frame = (state == S_IDLE) && (dirty || refresh_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_PWRUP;
            row   <= '0;
            col   <= '0;
            step  <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
            col   <= col_nx;
            step  <= step_nx;
        end
    end

    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        step_nx  = step;
        iss_init = 1'b0;
        iss_addr = 1'b0;
        iss_char = 1'b0;
        unique case (state)
            S_PWRUP: if (done) begin
                state_nx = S_INIT;
                step_nx  = '0;
                iss_init = 1'b1;
            end
            S_INIT: if (done) begin
                if (step == 4'(N_INIT - 1)) begin
                    state_nx = S_IDLE;
                end else begin
                    step_nx  = step + 4'd1;
                    iss_init = 1'b1;
                end
            end
            S_IDLE: if (dirty || refresh_req) begin
                state_nx = S_ROW_ADDR;
                row_nx   = '0;
                iss_addr = 1'b1;
            end
            S_ROW_ADDR: if (done) begin
                state_nx = S_CHAR;
                col_nx   = '0;
                iss_char = 1'b1;
            end
            S_CHAR: if (done) begin
                if (col != CW'(COLS - 1)) begin
                    col_nx   = col + 1'b1;
                    iss_char = 1'b1;
                end else if (row != RW'(ROWS - 1)) begin
                    state_nx = S_ROW_ADDR;
                    row_nx   = row + 1'b1;
                    iss_addr = 1'b1;
                end else begin
                    state_nx = S_FRAME_END;
                end
            end
            S_FRAME_END: state_nx = S_IDLE;
            default:     state_nx = S_PWRUP;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        frame_done = (state == S_FRAME_END);
    end

    // Byte for the transfer being launched; the buffer is read right here.
    always_comb begin
        init_k = (BUS4 || step_nx < 4'd3) ? step_nx : step_nx + 4'd1;
        rd_addr = AW'(int'(row_nx) * COLS + int'(col_nx));
        case (int'(row_nx))
            0:       row_off = 8'h00;
            1:       row_off = 8'h40;
            2:       row_off = 8'(COLS);
            default: row_off = 8'(8'h40 + COLS);
        endcase
        iss = iss_init | iss_addr | iss_char;
        iss_nib = iss_init && BUS4 && (init_k <= 4'd3);
        unique case (1'b1)
            iss_init: iss_byte = init_byte(init_k);
            iss_addr: iss_byte = 8'h80 | row_off;
            iss_char: iss_byte = fb[rd_addr];
            default:  iss_byte = 8'h00;
        endcase
        iss_wait = CNT_W'(CMD_CYC);
        if (iss_init) begin
            case (init_k)
                4'd0:    iss_wait = CNT_W'(I41_CYC);
                4'd1:    iss_wait = CNT_W'(I01_CYC);
                4'd6:    iss_wait = CNT_W'(CLR_CYC);
                default: iss_wait = CNT_W'(CMD_CYC);
            endcase
        end
    end

    // Reset parks the engine in WAIT so the power-up delay reuses the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= X_WAIT;
            cnt      <= PWR_CNT;
            wait_reg <= '0;
            lo_nib   <= '0;
            lo_pend  <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else if (iss) begin
            phase    <= X_SETUP;
            cnt      <= E_CNT;
            wait_reg <= iss_wait;
            lo_nib   <= iss_byte[3:0];
            lo_pend  <= BUS4 && !iss_nib;
            lcd_rs   <= iss_char;
            lcd_data <= BUS4 ? {iss_byte[7:4], 4'h0} : iss_byte;
        end else begin
            unique case (phase)
                X_SETUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        lcd_e <= 1'b1;
                        phase <= X_HIGH;
                        cnt   <= E_CNT;
                    end
                end
                X_HIGH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        lcd_e <= 1'b0;
                        if (lo_pend) begin
                            phase <= X_LOW;
                            cnt   <= E_CNT;
                        end else if (wait_reg == '0) begin
                            phase <= X_IDLE;
                        end else begin
                            phase <= X_WAIT;
                            cnt   <= wait_reg - 1'b1;
                        end
                    end
                end
                X_LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        lcd_data <= {lo_nib, 4'h0};
                        lo_pend  <= 1'b0;
                        phase    <= X_SETUP;
                        cnt      <= E_CNT;
                    end
                end
                X_WAIT: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           phase <= X_IDLE;
                end
                default: ;
            endcase
        end
    end

    // A write always wins over the clear that accompanies a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) fb[i] <= 8'h20;
            dirty <= 1'b1;
        end else begin
            if (wr_ok) fb[wr_addr] <= wr_data;
            if (wr_ok || (refresh_req && !start_frame)) dirty <= 1'b1;
            else if (start_frame)                       dirty <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lcd_frame_driver.sv
// Scoreboard bench for lcd_frame_driver: an 8-bit 4x16 panel and a
// 4-bit 2x3 panel, each checked byte/nibble by byte/nibble on E rise.
`timescale 1ns/1ps
module tb_lcd_frame_driver;
    typedef struct packed {
        logic       rs;
        logic [7:0] d;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8 = 1'b1, wr_en8 = 1'b0, ref8 = 1'b0;
    logic [5:0] wa8 = '0;
    logic [7:0] wd8 = '0;
    logic       busy8, fdone8, rs8, rw8, e8;
    logic [7:0] d8;

    logic       rst4 = 1'b1, wr_en4 = 1'b0, ref4 = 1'b0;
    logic [2:0] wa4 = '0;
    logic [7:0] wd4 = '0;
    logic       busy4, fdone4, rs4, rw4, e4;
    logic [7:0] d4;

    lcd_frame_driver #(
        .CLK_HZ(1_000_000), .ROWS(4), .COLS(16), .BUS_WIDTH(8),
        .POWERUP_US(100), .CMD_US(2), .CLEAR_US(5), .E_PULSE_CYC(2)
    ) u8 (
        .clk(clk), .rst(rst8), .wr_en(wr_en8), .wr_addr(wa8),
        .wr_data(wd8), .refresh_req(ref8), .busy(busy8),
        .frame_done(fdone8), .lcd_rs(rs8), .lcd_rw(rw8),
        .lcd_e(e8), .lcd_data(d8)
    );

    lcd_frame_driver #(
        .CLK_HZ(1_000_000), .ROWS(2), .COLS(3), .BUS_WIDTH(4),
        .POWERUP_US(100), .CMD_US(2), .CLEAR_US(5), .E_PULSE_CYC(2)
    ) u4 (
        .clk(clk), .rst(rst4), .wr_en(wr_en4), .wr_addr(wa4),
        .wr_data(wd4), .refresh_req(ref4), .busy(busy4),
        .frame_done(fdone4), .lcd_rs(rs4), .lcd_rw(rw4),
        .lcd_e(e4), .lcd_data(d4)
    );

    int   n_chk = 0, n_fail = 0;
    ev_t  q8[$], q4[$];
    ev_t  x8, x4;
    logic pe8 = 1'b0, pe4 = 1'b0;
    int   cyc8 = 0, cyc4 = 0, nfd8 = 0, nfd4 = 0;
    bit   rise8_chk = 1'b0, rise4_chk = 1'b0, u4_done = 1'b0;
    logic [7:0] m8 [64];
    logic [7:0] m4 [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got 0x%0h expected no transfer", nm, act);
    endtask

    task automatic push8(input logic rs, input logic [7:0] b);
        q8.push_back('{rs: rs, d: b});
    endtask

    task automatic push4(input logic rs, input logic [7:0] b, input bit single);
        q4.push_back('{rs: rs, d: {b[7:4], 4'h0}});
        if (!single) q4.push_back('{rs: rs, d: {b[3:0], 4'h0}});
    endtask

    task automatic push_init8();
        logic [7:0] t [8] = '{8'h30, 8'h30, 8'h30, 8'h38,
                             8'h08, 8'h01, 8'h06, 8'h0C};
        for (int i = 0; i < 8; i++) push8(1'b0, t[i]);
    endtask

    task automatic push_frame8();
        logic [7:0] off [4] = '{8'h80, 8'hC0, 8'h90, 8'hD0};
        for (int r = 0; r < 4; r++) begin
            push8(1'b0, off[r]);
            for (int c = 0; c < 16; c++) push8(1'b1, m8[r*16+c]);
        end
    endtask

    task automatic push_init4();
        logic [7:0] t [5] = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
        for (int i = 0; i < 3; i++) push4(1'b0, 8'h30, 1'b1);
        push4(1'b0, 8'h20, 1'b1);
        for (int i = 0; i < 5; i++) push4(1'b0, t[i], 1'b0);
    endtask

    task automatic push_frame4();
        logic [7:0] off [2] = '{8'h80, 8'hC0};
        for (int r = 0; r < 2; r++) begin
            push4(1'b0, off[r], 1'b0);
            for (int c = 0; c < 3; c++) push4(1'b1, m4[r*3+c], 1'b0);
        end
    endtask

    task automatic wait_fd(input int which, input int n, input int budget);
        int k = 0;
        while (((which == 8) ? nfd8 : nfd4) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (((which == 8) ? nfd8 : nfd4) < n)
            $display("FAIL wait_frame_done%0d: got %0d frames expected %0d",
                     which, (which == 8) ? nfd8 : nfd4, n);
        n_chk++;
        if (((which == 8) ? nfd8 : nfd4) < n) n_fail++;
    endtask

    initial forever begin
        @(posedge clk);
        if (rst8) cyc8 = 0; else cyc8++;
        if (rst4) cyc4 = 0; else cyc4++;
    end

    // Monitor: every rising E pops the next expected transfer.
    initial forever begin
        @(negedge clk);
        if (!rst8) begin
            if (fdone8) nfd8++;
            if (e8 && !pe8) begin
                if (rise8_chk) begin
                    chk("first_rise_cycle8", 32'(cyc8), 32'd102);
                    rise8_chk = 1'b0;
                end
                if (q8.size() == 0) begin
                    unexpected("extra_byte8", 32'({rw8, rs8, d8}));
                end else begin
                    x8 = q8.pop_front();
                    chk("lcd8_byte", 32'({rw8, rs8, d8}), 32'({1'b0, x8}));
                end
            end
        end
        if (!rst4) begin
            if (fdone4) nfd4++;
            if (e4 && !pe4) begin
                if (rise4_chk) begin
                    chk("first_rise_cycle4", 32'(cyc4), 32'd102);
                    rise4_chk = 1'b0;
                end
                if (q4.size() == 0) begin
                    unexpected("extra_nibble4", 32'({rw4, rs4, d4}));
                end else begin
                    x4 = q4.pop_front();
                    chk("lcd4_nibble", 32'({rw4, rs4, d4}), 32'({1'b0, x4}));
                end
            end
        end
        pe8 = e8;
        pe4 = e4;
    end

    // 4-bit panel
    initial begin
        for (int i = 0; i < 6; i++) m4[i] = 8'h20;
        repeat (3) @(negedge clk);
        chk("reset_e4", 32'(e4), 32'd0);
        chk("reset_data4", 32'(d4), 32'd0);
        push_init4();
        push_frame4();
        rise4_chk = 1'b1;
        rst4 = 1'b0;
        wait_fd(4, 1, 12000);
        repeat (40) @(negedge clk);
        wr_en4 = 1'b1; wa4 = 3'd6; wd4 = 8'h55;
        @(negedge clk);
        wr_en4 = 1'b0;
        repeat (200) @(negedge clk);
        chk("oob_write_no_frame4", 32'(nfd4), 32'd1);
        chk("queue_empty4_a", 32'(q4.size()), 32'd0);
        wr_en4 = 1'b1; wa4 = 3'd4; wd4 = 8'h41;
        m4[4] = 8'h41;
        push_frame4();
        @(negedge clk);
        wr_en4 = 1'b0;
        wait_fd(4, 2, 3000);
        repeat (100) @(negedge clk);
        chk("frames4", 32'(nfd4), 32'd2);
        chk("queue_empty4_b", 32'(q4.size()), 32'd0);
        u4_done = 1'b1;
    end

    // 8-bit panel and summary
    initial begin
        int k;
        for (int i = 0; i < 64; i++) m8[i] = 8'h20;
        repeat (3) @(negedge clk);
        chk("reset_e8", 32'(e8), 32'd0);
        chk("reset_rs8", 32'(rs8), 32'd0);
        chk("reset_rw8", 32'(rw8), 32'd0);
        chk("reset_data8", 32'(d8), 32'd0);
        chk("reset_busy8", 32'(busy8), 32'd1);
        chk("reset_frame_done8", 32'(fdone8), 32'd0);
        push_init8();
        push_frame8();
        rise8_chk = 1'b1;
        rst8 = 1'b0;
        repeat (1000) @(negedge clk);
        chk("busy_in_init8", 32'(busy8), 32'd1);
        wait_fd(8, 1, 12000);
        repeat (3) @(negedge clk);
        chk("busy_idle8", 32'(busy8), 32'd0);
        repeat (60) @(negedge clk);
        chk("frames8_a", 32'(nfd8), 32'd1);
        chk("queue_empty8_a", 32'(q8.size()), 32'd0);

        wr_en8 = 1'b1; wa8 = 6'd17; wd8 = 8'h41;
        m8[17] = 8'h41;
        push_frame8();
        @(negedge clk);
        wr_en8 = 1'b0;
        wait_fd(8, 2, 3000);
        repeat (60) @(negedge clk);
        chk("frames8_b", 32'(nfd8), 32'd2);
        chk("queue_empty8_b", 32'(q8.size()), 32'd0);

        wr_en8 = 1'b1; wa8 = 6'd0; wd8 = 8'h42; ref8 = 1'b1;
        m8[0] = 8'h42;
        push_frame8();
        push_frame8();
        @(negedge clk);
        wr_en8 = 1'b0; ref8 = 1'b0;
        wait_fd(8, 4, 3000);
        repeat (60) @(negedge clk);
        chk("frames8_same_cycle", 32'(nfd8), 32'd4);
        chk("queue_empty8_c", 32'(q8.size()), 32'd0);

        ref8 = 1'b1;
        push_frame8();
        @(negedge clk);
        ref8 = 1'b0;
        repeat (250) @(negedge clk);
        chk("busy_mid_frame8", 32'(busy8), 32'd1);
        wr_en8 = 1'b1; wa8 = 6'd2; wd8 = 8'h43;
        m8[2] = 8'h43;
        push_frame8();
        @(negedge clk);
        wr_en8 = 1'b0; ref8 = 1'b1;
        @(negedge clk);
        ref8 = 1'b0;
        wait_fd(8, 6, 3000);
        repeat (100) @(negedge clk);
        chk("frames8_mid", 32'(nfd8), 32'd6);
        chk("queue_empty8_d", 32'(q8.size()), 32'd0);

        ref8 = 1'b1;
        push_frame8();
        @(negedge clk);
        ref8 = 1'b0;
        k = 0;
        while (!(e8 && rs8) && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("char_e_high_seen8", 32'(e8 && rs8), 32'd1);
        #1 rst8 = 1'b1;
        #1;
        chk("async_reset_e8", 32'(e8), 32'd0);
        chk("async_reset_data8", 32'(d8), 32'd0);
        chk("async_reset_busy8", 32'(busy8), 32'd1);
        q8.delete();
        for (int i = 0; i < 64; i++) m8[i] = 8'h20;
        push_init8();
        push_frame8();
        @(negedge clk);
        rise8_chk = 1'b1;
        rst8 = 1'b0;
        wait_fd(8, 7, 12000);
        repeat (60) @(negedge clk);
        chk("frames8_after_reset", 32'(nfd8), 32'd7);
        chk("queue_empty8_e", 32'(q8.size()), 32'd0);
        chk("rise_check_done8", 32'(rise8_chk), 32'd0);

        k = 0;
        while (!u4_done && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("u4_sequence_done", 32'(u4_done), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
